// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path.
//   - UART_OVERSAMPLE : default number of baud_tick pulses per bit-time
//   - UART_DATA_BITS  : default number of data bits per frame
//   - rx_state_t      : receive framing FSM state encoding
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // Explicit encodings keep the state values stable for anyone probing
  // the state register in waveforms or legacy scripts.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_sync2.sv
// rx_sync2
//   Two-flop synchronizer that brings the asynchronous serial line into
//   the rx_clk domain. Both flops reset to 1 so the line reads as idle
//   while reset is asserted and immediately afterwards.
// Ports:
//   rx_clk   in  receive clock
//   reset_n  in  asynchronous active-low reset
//   async_in in  asynchronous serial input
//   sync_out out synchronized level
module rx_sync2 (
  input  logic rx_clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
//   Framing controller for an oversampled UART receiver. Detects the start
//   bit, qualifies it at its mid-point, samples each data bit at its
//   mid-point and checks the stop bit. Data bits are handed out one at a
//   time through shift/rx_bit to a downstream shift register.
// Parameters:
//   OVERSAMPLE  baud_tick pulses per bit-time (power of two, >= 8)
//   DATA_BITS   data bits per frame (5..9)
// Ports:
//   rx_clk      in   receive clock
//   reset_n     in   asynchronous active-low reset
//   baud_tick   in   one-cycle strobe at OVERSAMPLE x bit rate
//   enable      in   allows a new start bit to be accepted
//   rx_in       in   asynchronous serial line, idle high
//   shift       out  one-cycle strobe at the mid-point of each data bit
//   rx_bit      out  sampled data bit, valid while shift is high
//   bit_idx     out  index of the data bit being received (0 = LSB)
//   frame_done  out  one-cycle strobe after the stop bit is sampled
//   frame_err   out  framing error, only ever high together with frame_done
//   busy        out  high whenever the FSM is not idle
module rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic       rx_clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       enable,
  input  logic       rx_in,
  output logic       shift,
  output logic       rx_bit,
  output logic [3:0] bit_idx,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int TCW = $clog2(OVERSAMPLE);

  localparam logic [TCW-1:0] TICK_ONE  = TCW'(1);
  localparam logic [TCW-1:0] TICK_HALF = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     IDX_ONE   = 4'd1;
  localparam logic [3:0]     IDX_LAST  = 4'(DATA_BITS - 1);

  logic           rx_s;
  rx_state_t      state;
  rx_state_t      state_nxt;
  logic [TCW-1:0] tick_cnt;
  logic [TCW-1:0] tick_nxt;
  logic [3:0]     idx_nxt;
  logic           shift_nxt;
  logic           bit_nxt;
  logic           done_nxt;
  logic           err_nxt;

  rx_sync2 u_sync (
    .rx_clk   (rx_clk),
    .reset_n  (reset_n),
    .async_in (rx_in),
    .sync_out (rx_s)
  );

  // Next-state logic. Everything except the bit index only moves on a
  // baud_tick, so idle cycles between ticks leave the counters untouched.
  // The bit index advances in the cycle after a shift pulse, which keeps
  // bit_idx equal to the index of the bit being presented while shift is
  // high. The last shift moves the FSM to STOP in the same edge, so the
  // index then holds at DATA_BITS-1.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = 1'b0;
    bit_nxt   = rx_bit;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (shift && state == S_DATA) begin
      idx_nxt = bit_idx + IDX_ONE;
    end

    if (baud_tick) begin
      case (state)
        S_IDLE: begin
          // enable only gates the acceptance of a new frame.
          if (enable && !rx_s) begin
            state_nxt = S_START;
            tick_nxt  = '0;
            idx_nxt   = '0;
          end
        end

        S_START: begin
          // Half a bit-time in: a high line means the falling edge was a glitch.
          if (tick_cnt == TICK_HALF) begin
            tick_nxt  = '0;
            state_nxt = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        S_DATA: begin
          // A full bit-time after the start mid-point lands in mid data bit.
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            shift_nxt = 1'b1;
            bit_nxt   = rx_s;
            if (bit_idx == IDX_LAST) begin
              state_nxt = S_STOP;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        S_STOP: begin
          // A low stop bit is a framing error and may be the start of a
          // break, so wait for the line to recover before going idle.
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            done_nxt  = 1'b1;
            err_nxt   = !rx_s;
            state_nxt = rx_s ? S_IDLE : S_BREAK;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state_nxt = S_IDLE;
          end
        end

        default: begin
          state_nxt = S_IDLE;
          tick_nxt  = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers. Strobes are derived from next-state logic
  // so they rise on the edge that samples the qualifying baud_tick and
  // last exactly one cycle. busy follows the registered state.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= 1'b0;
      rx_bit     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      bit_idx    <= idx_nxt;
      shift      <= shift_nxt;
      rx_bit     <= bit_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl
//   Directed testbench for rx_frame_ctrl with OVERSAMPLE=16, DATA_BITS=8.
//   baud_tick fires once every three rx_clk cycles; serial frames are
//   driven a whole bit-time (16 ticks) per bit.
module tb_rx_frame_ctrl;
  import uart_pkg::*;

  logic       rx_clk = 1'b0;
  logic       reset_n;
  logic       baud_tick;
  logic       enable;
  logic       rx_in;
  logic       shift;
  logic       rx_bit;
  logic [3:0] bit_idx;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int tick_total  = 0;

  int         shift_cnt = 0;
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         viol_cnt  = 0;
  logic       rec_bit   [256];
  logic [3:0] rec_idx   [256];
  int         rec_stamp [256];

  rx_frame_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .rx_clk     (rx_clk),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .enable     (enable),
    .rx_in      (rx_in),
    .shift      (shift),
    .rx_bit     (rx_bit),
    .bit_idx    (bit_idx),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 rx_clk = ~rx_clk;

  // baud_tick: high for one rising edge out of every three.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (2) @(negedge rx_clk);
      baud_tick = 1'b1;
      tick_total++;
      @(negedge rx_clk);
      baud_tick = 1'b0;
    end
  end

  // Monitor: records every strobe and any illegal strobe combination.
  always @(negedge rx_clk) begin
    if (shift) begin
      rec_bit[shift_cnt[7:0]]   <= rx_bit;
      rec_idx[shift_cnt[7:0]]   <= bit_idx;
      rec_stamp[shift_cnt[7:0]] <= tick_total;
      shift_cnt <= shift_cnt + 1;
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if ((shift && frame_done) || (shift && frame_err) || (frame_err && !frame_done))
      viol_cnt <= viol_cnt + 1;
  end

  // Returns 1ns after the edge that sampled the n-th following baud_tick.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge rx_clk); while (baud_tick !== 1'b1);
    end
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; line left at the stop level.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    rx_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      wait_ticks(16);
    end
    rx_in = stop;
    wait_ticks(16);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    rx_in   = 1'b1;
    #22;
    vectors++; if (shift !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_shift: got %b expected 0", shift); end
    vectors++; if (rx_bit !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_bit: got %b expected 0", rx_bit); end
    vectors++; if (bit_idx !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_bit_idx: got %0d expected 0", bit_idx); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    @(negedge rx_clk);
    reset_n = 1'b1;
    wait_ticks(4);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_frame_55();
    int base = shift_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [7:0] got;
    send_frame(8'h55, 1'b1);
    wait_ticks(2);
    vectors++; if (shift_cnt - base !== 8) begin miscompares++; $display("[TB] FAIL f55_shift_count: got %0d expected 8", shift_cnt - base); end
    for (int i = 0; i < 8; i++) got[i] = rec_bit[base + i];
    vectors++; if (got !== 8'h55) begin miscompares++; $display("[TB] FAIL f55_data: got %h expected 55", got); end
    for (int i = 1; i < 8; i++) begin
      vectors++;
      if (rec_stamp[base + i] - rec_stamp[base + i - 1] !== 16) begin
        miscompares++;
        $display("[TB] FAIL f55_spacing[%0d]: got %0d expected 16", i, rec_stamp[base + i] - rec_stamp[base + i - 1]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rec_idx[base + i] !== 4'(i)) begin
        miscompares++;
        $display("[TB] FAIL f55_bit_idx[%0d]: got %0d expected %0d", i, rec_idx[base + i], i);
      end
    end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL f55_done: got %0d expected 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("[TB] FAIL f55_err: got %0d expected 0", err_cnt - e0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL f55_busy_after: got %b expected 0", busy); end
    vectors++; if (bit_idx !== 4'd7) begin miscompares++; $display("[TB] FAIL f55_bit_idx_hold: got %0d expected 7", bit_idx); end
  endtask

  task automatic test_glitch();
    int base = shift_cnt;
    int d0 = done_cnt;
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(4);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL glitch_in_start: got %b expected 1", busy); end
    wait_ticks(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_back_idle: got %b expected 0", busy); end
    wait_ticks(16);
    vectors++; if (shift_cnt - base !== 0) begin miscompares++; $display("[TB] FAIL glitch_shift: got %0d expected 0", shift_cnt - base); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("[TB] FAIL glitch_done: got %0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_break();
    int base = shift_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [7:0] got;
    send_frame(8'hA3, 1'b0);
    wait_ticks(24);
    for (int i = 0; i < 8; i++) got[i] = rec_bit[base + i];
    vectors++; if (got !== 8'hA3) begin miscompares++; $display("[TB] FAIL brk_data: got %h expected a3", got); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL brk_done: got %0d expected 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("[TB] FAIL brk_err: got %0d expected 1", err_cnt - e0); end
    vectors++; if (dut.state !== S_BREAK) begin miscompares++; $display("[TB] FAIL brk_state: got %0d expected %0d", dut.state, S_BREAK); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL brk_busy: got %b expected 1", busy); end
    rx_in = 1'b1;
    wait_ticks(3);
    vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("[TB] FAIL brk_exit_state: got %0d expected %0d", dut.state, S_IDLE); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL brk_exit_busy: got %b expected 0", busy); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL brk_no_extra_done: got %0d expected 1", done_cnt - d0); end
    vectors++; if (shift_cnt - base !== 8) begin miscompares++; $display("[TB] FAIL brk_shift_count: got %0d expected 8", shift_cnt - base); end
  endtask

  task automatic test_back_to_back();
    int base = shift_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [15:0] got;
    send_frame(8'h0F, 1'b1);
    send_frame(8'hF0, 1'b1);
    wait_ticks(2);
    vectors++; if (shift_cnt - base !== 16) begin miscompares++; $display("[TB] FAIL b2b_shift_count: got %0d expected 16", shift_cnt - base); end
    for (int i = 0; i < 16; i++) got[i] = rec_bit[base + i];
    vectors++; if (got !== 16'hF00F) begin miscompares++; $display("[TB] FAIL b2b_data: got %h expected f00f", got); end
    vectors++; if (done_cnt - d0 !== 2) begin miscompares++; $display("[TB] FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("[TB] FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_mid_reset();
    int base = shift_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [7:0] got;
    fork
      send_frame(8'hFC, 1'b1);
      begin
        int n = 0;
        int cyc = 0;
        while (n < 3 && cyc < 3000) begin
          @(negedge rx_clk);
          cyc++;
          if (shift) n++;
        end
        if (n < 3) begin
          vectors++; miscompares++;
          $display("[TB] FAIL mrst_wait_shift3: got %0d shifts expected 3", n);
        end else begin
          #1 reset_n = 1'b0;
          #1;
          vectors++;
          if ({shift, rx_bit, bit_idx, frame_done, frame_err, busy} !== 9'd0) begin
            miscompares++;
            $display("[TB] FAIL mrst_outputs: got %b expected 000000000",
                     {shift, rx_bit, bit_idx, frame_done, frame_err, busy});
          end
          wait_ticks(12);
          @(negedge rx_clk);
          reset_n = 1'b1;
        end
      end
    join
    wait_ticks(2);
    vectors++; if (shift_cnt - base !== 3) begin miscompares++; $display("[TB] FAIL mrst_discard_shift: got %0d expected 3", shift_cnt - base); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("[TB] FAIL mrst_discard_done: got %0d expected 0", done_cnt - d0); end
    base = shift_cnt;
    send_frame(8'h3C, 1'b1);
    wait_ticks(2);
    for (int i = 0; i < 8; i++) got[i] = rec_bit[base + i];
    vectors++; if (got !== 8'h3C) begin miscompares++; $display("[TB] FAIL mrst_next_data: got %h expected 3c", got); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL mrst_next_done: got %0d expected 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("[TB] FAIL mrst_next_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_enable();
    int base = shift_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [7:0] got;
    enable = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_ticks(4);
    vectors++; if (shift_cnt - base !== 0) begin miscompares++; $display("[TB] FAIL en0_shift: got %0d expected 0", shift_cnt - base); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("[TB] FAIL en0_done: got %0d expected 0", done_cnt - d0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL en0_busy: got %b expected 0", busy); end
    enable = 1'b1;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_ticks(4);
        enable = 1'b0;
      end
    join
    wait_ticks(2);
    for (int i = 0; i < 8; i++) got[i] = rec_bit[base + i];
    vectors++; if (shift_cnt - base !== 8) begin miscompares++; $display("[TB] FAIL endrop_shift: got %0d expected 8", shift_cnt - base); end
    vectors++; if (got !== 8'h5A) begin miscompares++; $display("[TB] FAIL endrop_data: got %h expected 5a", got); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("[TB] FAIL endrop_done: got %0d expected 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("[TB] FAIL endrop_err: got %0d expected 0", err_cnt - e0); end
    enable = 1'b1;
  endtask

  task automatic test_exclusive();
    vectors++;
    if (viol_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL strobe_exclusive: got %0d violations expected 0", viol_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_glitch();
    test_break();
    test_back_to_back();
    test_mid_reset();
    test_enable();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL global_timeout: got no completion expected finish before 600us");
    $fatal(1, "[TB] timeout");
  end

endmodule
